dmem_lsu_ram: RTL and testbench

- Parametrised successor to the single-cycle word-only data memory.
- Adds byte/half/word loads and stores with sign/zero extension, and a valid/ready request with pipelined read response.
- Reports misaligned, out-of-range and illegal-size accesses as errors.
- Zeroes its array with a post-reset clear sequencer instead of a bulk reset.
- Sits between the execute/memory stage of the RISC-V core and the writeback mux.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_lsu_ram_if.sv | 29 ++
 rtl/dmem_byte_ram.sv | 28 ++
 rtl/dmem_lsu_ram.sv | 162 ++++++++++++++++
 tb/tb_dmem_lsu_ram.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the LSU data memory: funct3 size codes, FSM
// state encoding and the byte-lane / load-extension helpers.
package dmem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Byte enables touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offset);
    logic [3:0] m;
    case (size)
      SIZE_B, SIZE_BU: m = 4'b0001 << offset;
      SIZE_H, SIZE_HU: m = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_W:          m = 4'b1111;
      default:         m = 4'b0000;
    endcase
    return m;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size,
                                              input logic [1:0] offset);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = {{24{b[7]}}, b};
      SIZE_BU: r = {24'h0, b};
      SIZE_H:  r = {{16{h[15]}}, h};
      SIZE_HU: r = {16'h0, h};
      SIZE_W:  r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_ram_if.sv
// Request/response bus between the memory stage and the data memory.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester keeps req_* stable while req_valid=1
// and req_ready=0. The response side has no ready: resp_valid is a single
// cycle strobe that the consumer must take, and resp_rdata/resp_err are 0
// whenever resp_valid is 0.
interface dmem_lsu_ram_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// Single-port word array with per-byte write enables and a registered
// read that returns the contents from before a same-edge write.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  input  logic             re,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write and read-before-write registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_lsu_ram.sv
// LSU data memory: byte/half/word loads and stores with extension, error
// detection, post-reset clear sequencer and a 1- or 2-stage read response.
module dmem_lsu_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int ADDR_W         = 32,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  dmem_lsu_ram_if.slave       bus,
  output logic                init_done,
  output logic [0:0]          dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] cnt;
  logic             ready;
  logic             accept;

  logic [2:0]       size;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             size_bad, align_bad, range_bad, req_err;

  logic             ram_we, ram_re;
  logic [3:0]       ram_be;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;

  logic             v1, err1, ld1;
  logic [2:0]       size1;
  logic [1:0]       off1;
  logic [31:0]      s1_rdata;
  logic             s1_err;

  // Clear sequencer: walks cnt over every word once, then parks in READY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_IDX) state <= ST_READY;
    end
  end

  // Gating with rst keeps ready low during reset even when no clear is run.
  assign ready         = (state == ST_READY) && rst;
  assign bus.req_ready = ready;
  assign init_done     = ready;
  assign dbg_state     = state;
  assign accept        = bus.req_valid && ready;

  assign size = bus.req_size;
  assign off  = bus.req_addr[1:0];
  assign idx  = bus.req_addr[IDX_W+1:2];

  assign size_bad  = (size == 3'b011) || (size == 3'b110) || (size == 3'b111) ||
                     (bus.req_we && ((size == SIZE_BU) || (size == SIZE_HU)));
  assign align_bad = (((size == SIZE_H) || (size == SIZE_HU)) && off[0]) ||
                     ((size == SIZE_W) && (off != 2'b00));

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign range_bad = |bus.req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign range_bad = 1'b0;
    end
  endgenerate

  assign req_err = size_bad || align_bad || range_bad;

  // RAM port: clear sequencer owns it during CLEAR, accepted requests after.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = idx;
    ram_wdata = 32'h0;
    ram_re    = accept;
    if ((state == ST_CLEAR) && rst) begin
      ram_we   = 1'b1;
      ram_be   = 4'b1111;
      ram_addr = cnt;
    end else if (accept && bus.req_we && !req_err) begin
      ram_we = 1'b1;
      ram_be = lane_mask(size, off);
      case (size)
        SIZE_B:  ram_wdata = {4{bus.req_wdata[7:0]}};
        SIZE_H:  ram_wdata = {2{bus.req_wdata[15:0]}};
        default: ram_wdata = bus.req_wdata;
      endcase
    end
  end

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // Stage 1: capture the request attributes alongside the RAM read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      err1  <= 1'b0;
      ld1   <= 1'b0;
      size1 <= 3'b000;
      off1  <= 2'b00;
    end else begin
      v1 <= accept;
      if (accept) begin
        err1  <= req_err;
        ld1   <= !bus.req_we;
        size1 <= size;
        off1  <= off;
      end
    end
  end

  assign s1_rdata = (v1 && ld1 && !err1) ? load_extend(ram_rdata, size1, off1) : 32'h0;
  assign s1_err   = v1 && err1;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic        v2, err2;
      logic [31:0] rdata2;
      // Stage 2: register the extended result for the longer latency.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v2     <= 1'b0;
          err2   <= 1'b0;
          rdata2 <= 32'h0;
        end else begin
          v2     <= v1;
          err2   <= s1_err;
          rdata2 <= s1_rdata;
        end
      end
      assign bus.resp_valid = v2;
      assign bus.resp_err   = err2;
      assign bus.resp_rdata = rdata2;
    end else begin : g_lat1
      assign bus.resp_valid = v1;
      assign bus.resp_err   = s1_err;
      assign bus.resp_rdata = s1_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_lsu_ram.sv
// Directed bench for dmem_lsu_ram: two 16-word instances, latency 1 and 2.
module tb_dmem_lsu_ram;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  logic init_done1, init_done2;
  logic [0:0] dbg_state1, dbg_state2;

  int checks;
  int errors;

  dmem_lsu_ram_if #(.ADDR_W(32)) bus1 ();
  dmem_lsu_ram_if #(.ADDR_W(32)) bus2 ();

  dmem_lsu_ram #(.DEPTH_WORDS(16), .ADDR_W(32), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .init_done(init_done1), .dbg_state(dbg_state1)
  );

  dmem_lsu_ram #(.DEPTH_WORDS(16), .ADDR_W(32), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .init_done(init_done2), .dbg_state(dbg_state2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: put one request on bus1 (sel=0) or bus2 (sel=1).
  task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
    if (!sel) begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
      bus1.req_size = size; bus1.req_wdata = wdata;
    end else begin
      bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = addr;
      bus2.req_size = size; bus2.req_wdata = wdata;
    end
  endtask

  // Driver: one latency-1 transaction on bus1, response captured mid-cycle.
  task automatic op1(input logic we, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, output logic v, output logic [31:0] d,
                     output logic e);
    @(negedge clk);
    drive(1'b0, 1'b1, we, addr, size, wdata);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    v = bus1.resp_valid;
    d = bus1.resp_rdata;
    e = bus1.resp_err;
  endtask

  // Count rising edges after reset release until init_done1 rises.
  task automatic wait_init(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (init_done1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    logic v, e;
    logic [31:0] d;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus1.resp_valid, bus1.resp_err, bus1.req_ready, init_done1} !== 4'b0000 ||
        bus1.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs1: got v=%b e=%b rdy=%b done=%b d=%h want all 0",
               bus1.resp_valid, bus1.resp_err, bus1.req_ready, init_done1, bus1.resp_rdata);
    end
    checks++;
    if ({bus2.resp_valid, bus2.resp_err, bus2.req_ready, init_done2} !== 4'b0000 ||
        bus2.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs2: got v=%b e=%b rdy=%b done=%b d=%h want all 0",
               bus2.resp_valid, bus2.resp_err, bus2.req_ready, init_done2, bus2.resp_rdata);
    end
    rst = 1'b1;
    wait_init(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clear_cycles: got %0d want 16", n);
    end
    checks++;
    if (init_done2 !== 1'b1 || bus2.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_done2: got done=%b rdy=%b want 1 1", init_done2, bus2.req_ready);
    end
    op1(1'b0, 32'h3C, SIZE_W, 32'h0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_3c_cleared: got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
  endtask

  task automatic test_extend();
    logic v, e;
    logic [31:0] d;
    logic [2:0]  sz [4];
    logic [31:0] ad [4];
    logic [31:0] ex [4];
    sz = '{SIZE_B, SIZE_BU, SIZE_H, SIZE_HU};
    ad = '{32'h10, 32'h10, 32'h12, 32'h12};
    ex = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000};
    op1(1'b1, 32'h10, SIZE_W, 32'h8000_80F0, v, d, e);
    checks++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_resp: got v=%b d=%h e=%b want 1 00000000 0", v, d, e);
    end
    for (int i = 0; i < 4; i++) begin
      op1(1'b0, ad[i], sz[i], 32'h0, v, d, e);
      checks++;
      if (v !== 1'b1 || d !== ex[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL extend_%0d: got v=%b d=%h e=%b want 1 %h 0", i, v, d, e, ex[i]);
      end
    end
  endtask

  task automatic test_lanes();
    logic v, e;
    logic [31:0] d;
    op1(1'b1, 32'h20, SIZE_W, 32'h1122_3344, v, d, e);
    op1(1'b1, 32'h21, SIZE_B, 32'h0000_00AA, v, d, e);
    op1(1'b0, 32'h20, SIZE_W, 32'h0, v, d, e);
    checks++;
    if (d !== 32'h1122_AA44 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb_lane: got d=%h e=%b want 1122aa44 0", d, e);
    end
    op1(1'b1, 32'h22, SIZE_H, 32'h0000_BEEF, v, d, e);
    op1(1'b0, 32'h20, SIZE_W, 32'h0, v, d, e);
    checks++;
    if (d !== 32'hBEEF_AA44 || e !== 1'b0) begin
      errors++;
      $display("FAIL sh_lane: got d=%h e=%b want beefaa44 0", d, e);
    end
  endtask

  task automatic test_errors();
    logic v, e;
    logic [31:0] d;
    logic        we [5];
    logic [31:0] ad [5];
    logic [2:0]  sz [5];
    we = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ad = '{32'h21, 32'h23, 32'h20, 32'h20, 32'h40};
    sz = '{SIZE_W, SIZE_H, 3'b011, SIZE_BU, SIZE_W};
    for (int i = 0; i < 5; i++) begin
      op1(we[i], ad[i], sz[i], 32'hFFFF_FFFF, v, d, e);
      checks++;
      if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
        errors++;
        $display("FAIL err_%0d: got v=%b d=%h e=%b want 1 00000000 1", i, v, d, e);
      end
    end
    op1(1'b0, 32'h20, SIZE_W, 32'h0, v, d, e);
    checks++;
    if (d !== 32'hBEEF_AA44 || e !== 1'b0) begin
      errors++;
      $display("FAIL err_no_write: got d=%h e=%b want beefaa44 0", d, e);
    end
  endtask

  // SW, LW, LH issued on consecutive cycles; per-negedge expected responses.
  task automatic test_back_to_back(input bit sel, input int lat, input logic [31:0] base);
    logic [31:0] exp_d [6];
    logic        exp_v [6];
    logic        rv, re;
    logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      exp_v[i] = 1'b0;
      exp_d[i] = 32'h0;
    end
    // Slot k is the negedge k half-cycles after the k-th accept edge window.
    exp_v[lat]     = 1'b1; exp_d[lat]     = 32'h0;
    exp_v[lat + 1] = 1'b1; exp_d[lat + 1] = 32'hCAFE_BABE;
    exp_v[lat + 2] = 1'b1; exp_d[lat + 2] = 32'hFFFF_CAFE;
    @(negedge clk);
    drive(sel, 1'b1, 1'b1, base, SIZE_W, 32'hCAFE_BABE);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b1, 1'b0, base, SIZE_W, 32'h0);
      else if (k == 2) drive(sel, 1'b1, 1'b0, base + 32'h2, SIZE_H, 32'h0);
      else drive(sel, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      rv = sel ? bus2.resp_valid : bus1.resp_valid;
      rd = sel ? bus2.resp_rdata : bus1.resp_rdata;
      re = sel ? bus2.resp_err   : bus1.resp_err;
      checks++;
      if (rv !== exp_v[k] || rd !== exp_d[k] || re !== 1'b0) begin
        errors++;
        $display("FAIL b2b_lat%0d_slot%0d: got v=%b d=%h e=%b want %b %h 0",
                 lat, k, rv, rd, re, exp_v[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    logic v, e;
    logic [31:0] d;
    op1(1'b1, 32'h04, SIZE_W, 32'h5555_5555, v, d, e);
    op1(1'b1, 32'h28, SIZE_W, 32'h6666_6666, v, d, e);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (init_done1 !== 1'b0 || dbg_state1 !== ST_CLEAR) begin
      errors++;
      $display("FAIL mid_clear_state: got done=%b st=%b want 0 0", init_done1, dbg_state1);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if ({bus1.resp_valid, bus1.resp_err, bus1.req_ready, init_done1} !== 4'b0000 ||
        bus1.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: got v=%b e=%b rdy=%b done=%b d=%h want all 0",
               bus1.resp_valid, bus1.resp_err, bus1.req_ready, init_done1, bus1.resp_rdata);
    end
    @(negedge clk);
    rst = 1'b1;
    wait_init(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL restart_clear_cycles: got %0d want 16", n);
    end
    op1(1'b0, 32'h04, SIZE_W, 32'h0, v, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL cleared_word1: got d=%h e=%b want 00000000 0", d, e);
    end
    op1(1'b0, 32'h28, SIZE_W, 32'h0, v, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL cleared_word10: got d=%h e=%b want 00000000 0", d, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_extend();
    test_lanes();
    test_errors();
    test_back_to_back(1'b0, 1, 32'h08);
    test_back_to_back(1'b1, 2, 32'h08);
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
